// File: rtl/gray_code_converter_pkg.sv
// -----------------------------------------------------------------------------
// gray_code_converter_pkg
// Shared constants and width-generic Gray conversion helpers.
//
// The helpers work on a fixed GRAY_BW_MAX-bit word. Callers zero-extend a
// BW_DATA-bit operand and truncate the result back to BW_DATA bits. This is
// exact for any BW_DATA <= GRAY_BW_MAX:
//   - bin ^ (bin >> 1) shifts a zero into the operand MSB, as the logical
//     shift requires.
//   - The MSB-down prefix XOR only accumulates zeros above the operand MSB.
//
// Optional feature macro used by the top level: GRAY_ROUNDTRIP_CHECK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package gray_code_converter_pkg;

  localparam int GRAY_BW_DEFAULT = 8;
  localparam int GRAY_BW_MAX     = 64;

  typedef logic [GRAY_BW_MAX-1:0] gray_word_t;

  // Binary to Gray: every bit is XORed with its more-significant neighbour.
  function automatic gray_word_t f_bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 7'd1);
  endfunction

  // Gray to binary: running XOR from the MSB down.
  function automatic gray_word_t f_gray2bin(input gray_word_t gray);
    gray_word_t bin;
    logic       acc;
    bin = {GRAY_BW_MAX{1'b0}};
    acc = 1'b0;
    for (int k = GRAY_BW_MAX - 1; k >= 0; k--) begin
      acc    = acc ^ gray[k];
      bin[k] = acc;
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_code_converter_prefix_xor.sv
// -----------------------------------------------------------------------------
// gray_prefix_xor
// Combinational Gray-to-binary converter built as an MSB-down prefix-XOR chain.
//
// Ports:
//   i_gray [BW_DATA-1:0]  Gray-coded operand.
//   o_bin  [BW_DATA-1:0]  Binary value; o_bin[k] = XOR of i_gray[BW_DATA-1:k].
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module gray_prefix_xor
  import gray_code_converter_pkg::*;
#(
  parameter int BW_DATA = GRAY_BW_DEFAULT
) (
  input  logic [BW_DATA-1:0] i_gray,
  output logic [BW_DATA-1:0] o_bin
);

  logic acc_s;

  // Prefix-XOR chain. A scalar accumulator is used so that no bit of o_bin
  // reads another bit of the same vector.
  always_comb begin
    o_bin = {BW_DATA{1'b0}};
    acc_s = 1'b0;
    for (int k = BW_DATA - 1; k >= 0; k--) begin
      acc_s    = acc_s ^ i_gray[k];
      o_bin[k] = acc_s;
    end
  end

endmodule

// File: rtl/gray_code_converter.sv
// -----------------------------------------------------------------------------
// gray_code_converter
// Registered bidirectional Gray-code converter with a 1-cycle latency.
// Two independent paths (binary->Gray and Gray->binary) share one valid
// qualifier and one output register stage. While i_valid is low the data
// outputs hold their last value and o_valid drops.
//
// Parameters:
//   BW_DATA  data width in bits (2 .. GRAY_BW_MAX).
//
// Ports:
//   i_clk     clock, rising edge.
//   i_rstn    asynchronous active-low reset; clears all outputs.
//   i_valid   qualifies i_bin and i_gray.
//   i_bin     binary operand for the binary-to-Gray path.
//   i_gray    Gray operand for the Gray-to-binary path.
//   o_valid   registered i_valid.
//   o_gray    Gray code of the last valid i_bin.
//   o_bin     binary value of the last valid i_gray.
//
//   The following ports exist only with GRAY_ROUNDTRIP_CHECK_EN defined:
//   o_rt_bin  gray_to_bin(bin_to_gray(i_bin)) of the last valid i_bin.
//   o_err     one-cycle flag: the round trip did not reproduce i_bin.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module gray_code_converter
  import gray_code_converter_pkg::*;
#(
  parameter int BW_DATA = GRAY_BW_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_valid,
  input  logic [BW_DATA-1:0] i_bin,
  input  logic [BW_DATA-1:0] i_gray,
  output logic               o_valid,
  output logic [BW_DATA-1:0] o_gray,
  output logic [BW_DATA-1:0] o_bin
`ifdef GRAY_ROUNDTRIP_CHECK_EN
  ,
  output logic [BW_DATA-1:0] o_rt_bin,
  output logic               o_err
`endif
);

  logic [BW_DATA-1:0] gray_calc_s;
  logic [BW_DATA-1:0] bin_calc_s;

  logic               valid_d, valid_q;
  logic [BW_DATA-1:0] gray_d,  gray_q;
  logic [BW_DATA-1:0] bin_d,   bin_q;

  // Binary-to-Gray path. The operand is zero-extended into the helper's
  // wide word and the result is truncated back to BW_DATA bits.
  always_comb begin
    gray_calc_s = BW_DATA'(f_bin2gray(GRAY_BW_MAX'(i_bin)));
  end

  gray_prefix_xor #(
    .BW_DATA (BW_DATA)
  ) u_prefix_xor (
    .i_gray (i_gray),
    .o_bin  (bin_calc_s)
  );

`ifdef GRAY_ROUNDTRIP_CHECK_EN
  logic [BW_DATA-1:0] rt_calc_s;
  logic               rt_bad_s;
  logic [BW_DATA-1:0] rt_bin_d, rt_bin_q;
  logic               err_d,    err_q;

  // Round trip through both helpers. The Gray value comes from the same
  // logic that feeds o_gray, so a fault in that path shows up here.
  always_comb begin
    rt_calc_s = BW_DATA'(f_gray2bin(GRAY_BW_MAX'(gray_calc_s)));
    rt_bad_s  = (rt_calc_s != i_bin);
  end

  // Next state of the check registers. The error flag lasts one cycle.
  always_comb begin
    rt_bin_d = rt_bin_q;
    err_d    = 1'b0;
    if (i_valid) begin
      rt_bin_d = rt_calc_s;
      err_d    = rt_bad_s;
    end else begin
      rt_bin_d = rt_bin_q;
      err_d    = 1'b0;
    end
  end

  // Check register stage.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rt_bin_q <= {BW_DATA{1'b0}};
      err_q    <= 1'b0;
    end else begin
      rt_bin_q <= rt_bin_d;
      err_q    <= err_d;
    end
  end

  assign o_rt_bin = rt_bin_q;
  assign o_err    = err_q;
`endif

  // Next state of the main registers. The data outputs hold while invalid.
  always_comb begin
    valid_d = i_valid;
    gray_d  = gray_q;
    bin_d   = bin_q;
    if (i_valid) begin
      gray_d = gray_calc_s;
      bin_d  = bin_calc_s;
    end else begin
      gray_d = gray_q;
      bin_d  = bin_q;
    end
  end

  // Main output register stage.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q <= 1'b0;
      gray_q  <= {BW_DATA{1'b0}};
      bin_q   <= {BW_DATA{1'b0}};
    end else begin
      valid_q <= valid_d;
      gray_q  <= gray_d;
      bin_q   <= bin_d;
    end
  end

  assign o_valid = valid_q;
  assign o_gray  = gray_q;
  assign o_bin   = bin_q;

endmodule

// File: tb/tb_gray_code_converter.sv
`timescale 1ns/1ps
module tb_gray_code_converter;

  localparam int BW = 8;
  localparam int NV = 256;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_valid;
  logic [BW-1:0] i_bin;
  logic [BW-1:0] i_gray;
  logic          o_valid;
  logic [BW-1:0] o_gray;
  logic [BW-1:0] o_bin;
`ifdef GRAY_ROUNDTRIP_CHECK_EN
  logic [BW-1:0] o_rt_bin;
  logic          o_err;
`endif

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  gray_code_converter #(.BW_DATA(BW)) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_valid  (i_valid),
    .i_bin    (i_bin),
    .i_gray   (i_gray),
    .o_valid  (o_valid),
    .o_gray   (o_gray),
    .o_bin    (o_bin)
`ifdef GRAY_ROUNDTRIP_CHECK_EN
    ,
    .o_rt_bin (o_rt_bin),
    .o_err    (o_err)
`endif
  );

  // Reference model.
  // Gray code of a value is v XOR (v >> 1).
  // Gray-to-binary is the inverse lookup of that mapping over all codes.
  logic [BW-1:0] bin_of_gray [0:NV-1];

  function automatic logic [BW-1:0] m_b2g(input logic [BW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs, following the 1-cycle-latency/hold/reset rules.
  logic          exp_valid;
  logic [BW-1:0] exp_gray, exp_bin, exp_rt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_valid <= 1'b0;
      exp_gray  <= '0;
      exp_bin   <= '0;
      exp_rt    <= '0;
    end else begin
      exp_valid <= i_valid;
      if (i_valid) begin
        exp_gray <= m_b2g(i_bin);
        exp_bin  <= bin_of_gray[i_gray];
        exp_rt   <= i_bin;
      end
    end
  end

  // Cycle-by-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_valid", 64'(o_valid), 64'(exp_valid));
      check("cyc_gray",  64'(o_gray),  64'(exp_gray));
      check("cyc_bin",   64'(o_bin),   64'(exp_bin));
`ifdef GRAY_ROUNDTRIP_CHECK_EN
      check("cyc_rt_bin", 64'(o_rt_bin), 64'(exp_rt));
      check("cyc_err",    64'(o_err),    64'd0);
`endif
    end
  end

  // Inputs change 1 ns after a rising edge; outputs are read 1 ns after the
  // next rising edge.
  task automatic drive(input logic v, input logic [BW-1:0] b, input logic [BW-1:0] g);
    i_valid = v;
    i_bin   = b;
    i_gray  = g;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, 64'(o_valid), 64'd0);
    check({name, "_gray"},  64'(o_gray),  64'd0);
    check({name, "_bin"},   64'(o_bin),   64'd0);
`ifdef GRAY_ROUNDTRIP_CHECK_EN
    check({name, "_rt"},    64'(o_rt_bin), 64'd0);
    check({name, "_err"},   64'(o_err),    64'd0);
`endif
  endtask

  // Asserts reset between edges; the outputs must clear without a clock.
  task automatic reset_pulse(input string name);
    rstn = 1'b0;
    #1;
    check_zero(name);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [BW-1:0] prev_g;
    int filled;
    logic seen [0:NV-1];

    // Build and validate the inverse table: the mapping must be bijective.
    for (int v = 0; v < NV; v++) seen[v] = 1'b0;
    for (int v = 0; v < NV; v++) begin
      bin_of_gray[m_b2g(8'(v))] = 8'(v);
      seen[m_b2g(8'(v))] = 1'b1;
    end
    filled = 0;
    for (int v = 0; v < NV; v++) if (seen[v]) filled++;
    check("model_bijective", 64'(filled), 64'd256);

    // 1. Reset held with valid input present.
    rstn    = 1'b0;
    i_valid = 1'b1;
    i_bin   = 8'h55;
    i_gray  = 8'h00;
    #1 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_hold");
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", 64'(o_valid), 64'd1);
    check("release_gray",  64'(o_gray),  64'h7F);
    check("release_bin",   64'(o_bin),   64'h00);

    // 2. Basic conversions.
    drive(1'b1, 8'h05, 8'h07);
    check("basic_gray",  64'(o_gray),  64'h07);
    check("basic_bin",   64'(o_bin),   64'h05);
    check("basic_valid", 64'(o_valid), 64'd1);

    // 3. Wrap-around codes.
    drive(1'b1, 8'hFF, 8'h80);
    check("wrap_gray", 64'(o_gray), 64'h80);
    check("wrap_bin",  64'(o_bin),  64'hFF);
    drive(1'b1, 8'h63, 8'h52);
    check("b63_gray", 64'(o_gray), 64'h52);
    check("g52_bin",  64'(o_bin),  64'h63);

    // 4. Hold while invalid.
    drive(1'b1, 8'h0A, 8'h0F);
    check("pre_hold_gray", 64'(o_gray), 64'h0F);
    drive(1'b0, 8'h33, 8'h00);
    check("hold_gray",  64'(o_gray),  64'h0F);
    check("hold_bin",   64'(o_bin),   64'h0A);
    check("hold_valid", 64'(o_valid), 64'd0);

    // 5. Sweep with o_gray fed back into i_gray.
    prev_g = 8'h00;
    for (int n = 0; n < 100; n++) begin
      drive(1'b1, 8'(n), o_gray);
      if (n >= 1) begin
        check("sweep_roundtrip", 64'(o_bin), 64'(n - 1));
        check("sweep_one_bit", 64'($countones(o_gray ^ prev_g)), 64'd1);
      end
      prev_g = o_gray;
    end

    // Random traffic with occasional mid-stream resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_pulse("rand_reset");
      end else begin
        drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
      end
    end

`ifdef GRAY_ROUNDTRIP_CHECK_EN
    // 6. Exhaustive round trip, with a reset pulse in the middle.
    for (int n = 0; n < NV; n++) begin
      drive(1'b1, 8'(n), 8'($urandom));
      check("rt_value", 64'(o_rt_bin), 64'(n));
      check("rt_err",   64'(o_err),    64'd0);
      if (n == 128) reset_pulse("rt_reset");
    end
`endif

    drive(1'b0, 8'h00, 8'h00);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
